// File: rtl/axi_mm_axis_reader_pkg.sv
// Shared AXI encodings, 4 KiB boundary and FSM state type for the memory-to-stream reader.
package axi_mm_axis_reader_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam int unsigned BOUNDARY_4K = 4096;

    typedef enum logic [1:0] {
        StIdle,
        StAr,
        StR
    } state_t;

endpackage

// File: rtl/axi_mm_axis_reader_skid_buf.sv
// Two-entry registered skid buffer; the output is always driven straight from a register.
module axi_mm_axis_reader_skid_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_full,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] mem_q [2];
    logic [1:0]       count_q;
    logic             push;
    logic             pop;
    logic             wr_hi;

    assign out_data  = mem_q[0];
    assign out_valid = (count_q != 2'd0);
    assign in_full   = (count_q == 2'd2);
    assign pop       = out_valid & out_ready;
    // A push while full is only legal when the head leaves in the same cycle.
    assign push      = in_valid & (!in_full | pop);
    assign wr_hi     = (count_q == 2'd2) | ((count_q == 2'd1) & !pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            count_q  <= 2'd0;
        end else begin
            if (pop) begin
                mem_q[0] <= mem_q[1];
            end
            if (push) begin
                if (wr_hi) begin
                    mem_q[1] <= in_data;
                end else begin
                    mem_q[0] <= in_data;
                end
            end
            count_q <= count_q + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/axi_mm_axis_reader.sv
// Fetches a byte range over AXI4 INCR read bursts and emits it as one AXI-Stream packet.
module axi_mm_axis_reader
    import axi_mm_axis_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 512,
    parameter int unsigned KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int unsigned ADDR_WIDTH    = 34,
    parameter int unsigned ID_WIDTH      = 8,
    parameter int unsigned LEN_WIDTH     = 20,
    parameter int unsigned MAX_BURST_LEN = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    output logic                  busy,
    output logic                  error,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready
);

    localparam int unsigned OFF_W  = $clog2(KEEP_WIDTH);
    localparam int unsigned BLEN_W = 9;
    localparam int unsigned SKID_W = DATA_WIDTH + KEEP_WIDTH + 1;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  beats_left_q;
    logic [LEN_WIDTH-1:0]  out_left_q;
    logic [BLEN_W-1:0]     burst_rem_q;
    logic [KEEP_WIDTH-1:0] keep_last_q;
    logic                  error_q;
    logic                  arvalid_q;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic [7:0]            arlen_q;

    logic                  cmd_fire;
    logic                  r_fire;
    logic                  issue;
    logic                  skid_full;
    logic                  skid_valid;
    logic                  last_beat;
    logic [LEN_WIDTH:0]    len_round;
    logic [LEN_WIDTH-1:0]  cmd_beats;
    logic [OFF_W-1:0]      rem;
    logic [KEEP_WIDTH-1:0] cmd_keep;
    logic [ADDR_WIDTH-1:0] calc_addr;
    logic [LEN_WIDTH-1:0]  calc_left;
    logic [12:0]           to_bnd;
    logic [BLEN_W-1:0]     blen;
    logic [SKID_W-1:0]     skid_in;
    logic [SKID_W-1:0]     skid_out;
    logic                  unused_ok;

    assign unused_ok = ^{m_axi_rid, m_axi_rlast, m_axi_rresp[0]};

    assign cmd_ready    = (state_q == StIdle) & !skid_valid;
    assign busy         = (state_q != StIdle) | skid_valid;
    assign error        = error_q;
    assign m_axi_rready = (state_q == StR) & !skid_full;
    assign cmd_fire     = cmd_valid & cmd_ready;
    assign r_fire       = m_axi_rvalid & m_axi_rready;
    assign last_beat    = (out_left_q == LEN_WIDTH'(1));

    assign m_axi_arid    = '0;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = 3'(OFF_W);
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'd0;
    assign m_axi_arprot  = 3'd0;
    assign m_axi_arvalid = arvalid_q;

    assign len_round = {1'b0, cmd_len} + (LEN_WIDTH + 1)'(KEEP_WIDTH - 1);
    assign cmd_beats = LEN_WIDTH'(len_round >> OFF_W);
    assign rem       = cmd_len[OFF_W-1:0];

    always_comb begin
        cmd_keep = '0;
        for (int i = 0; i < int'(KEEP_WIDTH); i++) begin
            cmd_keep[i] = (rem == '0) || ((OFF_W + 1)'(i) < {1'b0, rem});
        end
    end

    // Next burst: limited by remaining beats, max burst length and the next 4 KiB boundary.
    always_comb begin
        calc_addr = (state_q == StIdle) ? cmd_addr : addr_q;
        calc_left = (state_q == StIdle) ? cmd_beats : beats_left_q;
        to_bnd    = (13'(BOUNDARY_4K) - {1'b0, calc_addr[11:0]}) >> OFF_W;
        blen      = BLEN_W'(MAX_BURST_LEN);
        if (calc_left < LEN_WIDTH'(blen)) begin
            blen = BLEN_W'(calc_left);
        end
        if ({4'b0, blen} > to_bnd) begin
            blen = BLEN_W'(to_bnd);
        end
    end

    assign issue = ((state_q == StIdle) & cmd_fire & (cmd_len != '0)) |
                   ((state_q == StR) & r_fire & (burst_rem_q == BLEN_W'(1)) &
                    (beats_left_q != '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            beats_left_q <= '0;
            out_left_q   <= '0;
            burst_rem_q  <= '0;
            keep_last_q  <= '0;
            error_q      <= 1'b0;
            arvalid_q    <= 1'b0;
            araddr_q     <= '0;
            arlen_q      <= '0;
        end else begin
            if (r_fire) begin
                burst_rem_q <= burst_rem_q - BLEN_W'(1);
                out_left_q  <= out_left_q - LEN_WIDTH'(1);
                if (m_axi_rresp[1]) begin
                    error_q <= 1'b1;
                end
            end
            unique case (state_q)
                StIdle: begin
                    if (cmd_fire) begin
                        error_q     <= 1'b0;
                        out_left_q  <= cmd_beats;
                        keep_last_q <= cmd_keep;
                    end
                end
                StAr: begin
                    if (m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        state_q   <= StR;
                    end
                end
                StR: begin
                    // Burst end follows the internal beat count; rlast is not trusted.
                    if (r_fire && burst_rem_q == BLEN_W'(1) && beats_left_q == '0) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
            if (issue) begin
                arvalid_q    <= 1'b1;
                araddr_q     <= calc_addr;
                arlen_q      <= 8'(blen - BLEN_W'(1));
                burst_rem_q  <= blen;
                beats_left_q <= calc_left - LEN_WIDTH'(blen);
                addr_q       <= calc_addr + (ADDR_WIDTH'(blen) << OFF_W);
                state_q      <= StAr;
            end
        end
    end

    assign skid_in = {m_axi_rdata, last_beat ? keep_last_q : {KEEP_WIDTH{1'b1}}, last_beat};

    axi_mm_axis_reader_skid_buf #(
        .WIDTH(SKID_W)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (skid_in),
        .in_valid (r_fire),
        .in_full  (skid_full),
        .out_data (skid_out),
        .out_valid(skid_valid),
        .out_ready(m_axis_tready)
    );

    assign m_axis_tvalid = skid_valid;
    assign m_axis_tdata  = skid_out[SKID_W-1 -: DATA_WIDTH];
    assign m_axis_tkeep  = skid_out[KEEP_WIDTH:1];
    assign m_axis_tlast  = skid_out[0];

endmodule

// File: tb/tb_axi_mm_axis_reader.sv
// Directed bench for axi_mm_axis_reader: AXI read slave model, stream sink and per-scenario checks.
module tb_axi_mm_axis_reader;

    localparam int DW = 512;
    localparam int KW = 64;
    localparam int AW = 34;
    localparam int IW = 8;
    localparam int LW = 20;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    len;
    } ar_t;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          busy;
    logic          error;
    logic [IW-1:0] m_axi_arid;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic [2:0]    m_axi_arsize;
    logic [1:0]    m_axi_arburst;
    logic          m_axi_arlock;
    logic [3:0]    m_axi_arcache;
    logic [2:0]    m_axi_arprot;
    logic          m_axi_arvalid;
    logic          m_axi_arready;
    logic [IW-1:0] m_axi_rid;
    logic [DW-1:0] m_axi_rdata;
    logic [1:0]    m_axi_rresp;
    logic          m_axi_rlast;
    logic          m_axi_rvalid;
    logic          m_axi_rready;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready;

    int          total;
    int          bad;
    int unsigned tready_pct;
    int          err_beat;
    int          resp_cnt;
    int          occ;
    int          max_occ;
    ar_t         ar_log[$];
    ar_t         ar_pend[$];
    beat_t       got[$];

    axi_mm_axis_reader #(
        .DATA_WIDTH   (DW),
        .KEEP_WIDTH   (KW),
        .ADDR_WIDTH   (AW),
        .ID_WIDTH     (IW),
        .LEN_WIDTH    (LW),
        .MAX_BURST_LEN(16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_addr     (cmd_addr),
        .cmd_len      (cmd_len),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .busy         (busy),
        .error        (error),
        .m_axi_arid   (m_axi_arid),
        .m_axi_araddr (m_axi_araddr),
        .m_axi_arlen  (m_axi_arlen),
        .m_axi_arsize (m_axi_arsize),
        .m_axi_arburst(m_axi_arburst),
        .m_axi_arlock (m_axi_arlock),
        .m_axi_arcache(m_axi_arcache),
        .m_axi_arprot (m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rid    (m_axi_rid),
        .m_axi_rdata  (m_axi_rdata),
        .m_axi_rresp  (m_axi_rresp),
        .m_axi_rlast  (m_axi_rlast),
        .m_axi_rvalid (m_axi_rvalid),
        .m_axi_rready (m_axi_rready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave and sink handshakes are driven half a cycle away from the sampling edge.
    always @(negedge clk) begin
        m_axi_arready = ($urandom_range(0, 1) == 1);
        m_axis_tready = ($urandom_range(0, 99) < tready_pct);
    end

    always @(posedge clk) begin
        if (rst_n && m_axi_arvalid && m_axi_arready) begin
            ar_log.push_back({m_axi_araddr, m_axi_arlen});
            ar_pend.push_back({m_axi_araddr, m_axi_arlen});
        end
        if (rst_n && m_axis_tvalid && m_axis_tready) begin
            got.push_back({m_axis_tdata, m_axis_tkeep, m_axis_tlast});
        end
    end

    // Beats held between R acceptance and stream acceptance; a 2-entry skid never holds more.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ = 0;
        end else begin
            occ = occ + int'(m_axi_rvalid && m_axi_rready) - int'(m_axis_tvalid && m_axis_tready);
            if (occ > max_occ) max_occ = occ;
        end
    end

    // Read data for a beat is its byte address replicated across the bus.
    initial begin : r_slave
        ar_t         e;
        logic [31:0] w;
        m_axi_rvalid = 1'b0;
        m_axi_rdata  = '0;
        m_axi_rresp  = 2'b00;
        m_axi_rlast  = 1'b0;
        m_axi_rid    = '0;
        forever begin
            @(posedge clk);
            if (rst_n && ar_pend.size() != 0) begin
                e = ar_pend.pop_front();
                for (int i = 0; i <= int'(e.len); i++) begin
                    #1;
                    w            = 32'(e.a) + 32'(i * KW);
                    m_axi_rvalid = 1'b1;
                    m_axi_rdata  = {16{w}};
                    m_axi_rlast  = (i == int'(e.len));
                    m_axi_rresp  = (resp_cnt == err_beat) ? 2'b10 : 2'b00;
                    do @(posedge clk); while (rst_n && !m_axi_rready);
                    if (!rst_n) break;
                    resp_cnt++;
                end
                #1;
                m_axi_rvalid = 1'b0;
                m_axi_rlast  = 1'b0;
            end
        end
    end

    function automatic beat_t exp_beat(input logic [AW-1:0] start, input int i, input int len);
        beat_t       b;
        logic [31:0] w;
        int          n;
        n   = (len + KW - 1) / KW;
        w   = 32'(start) + 32'(i * KW);
        b.d = {16{w}};
        b.l = (i == n - 1);
        b.k = '1;
        if (b.l && (len % KW) != 0) b.k = (64'd1 << (len % KW)) - 64'd1;
        return b;
    endfunction

    function automatic beat_t got_at(input int i);
        return (i < got.size()) ? got[i] : '0;
    endfunction

    function automatic ar_t ar_at(input int i);
        return (i < ar_log.size()) ? ar_log[i] : '0;
    endfunction

    task automatic run_cmd(input logic [AW-1:0] a, input int len, output bit ok,
                           output logic arv1, output logic err1, output int cyc);
        int n;
        bit acc;
        ok       = 1'b1;
        resp_cnt = 0;
        got.delete();
        ar_log.delete();
        @(negedge clk);
        cmd_addr  = a;
        cmd_len   = LW'(len);
        cmd_valid = 1'b1;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            @(posedge clk);
            acc = cmd_ready;
            n++;
        end
        #1 cmd_valid = 1'b0;
        if (!acc) ok = 1'b0;
        @(negedge clk);
        arv1 = m_axi_arvalid;
        err1 = error;
        cyc  = 0;
        while (!cmd_ready && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        if (!cmd_ready) ok = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({cmd_ready, busy, error} !== 3'b100) begin
            bad++;
            $display("FAIL reset_status: got rdy/busy/err=%b want 100", {cmd_ready, busy, error});
        end
        total++;
        if ({m_axi_arvalid, m_axi_rready, m_axis_tvalid, m_axis_tlast} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_valids: got %b want 0000",
                     {m_axi_arvalid, m_axi_rready, m_axis_tvalid, m_axis_tlast});
        end
        total++;
        if (m_axis_tdata !== '0 || m_axis_tkeep !== '0 || m_axi_araddr !== '0) begin
            bad++;
            $display("FAIL reset_data: got tkeep=%h araddr=%h want 0", m_axis_tkeep, m_axi_araddr);
        end
    endtask

    task automatic test_single_burst();
        bit   ok;
        logic arv1, err1;
        int   cyc;
        run_cmd(34'h1000, 256, ok, arv1, err1, cyc);
        total++;
        if (!ok) begin bad++; $display("FAIL single_done: got timeout want completion"); end
        total++;
        if (arv1 !== 1'b1) begin bad++; $display("FAIL single_ar_lat: got %b want 1", arv1); end
        total++;
        if (ar_log.size() != 1 || ar_at(0) !== {34'h1000, 8'd3}) begin
            bad++;
            $display("FAIL single_ar: got n=%0d ar=%h want n=1 ar=%h", ar_log.size(), ar_at(0),
                     {34'h1000, 8'd3});
        end
        total++;
        if ({m_axi_arid, m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot}
            !== {8'd0, 3'd6, 2'b01, 1'b0, 4'd0, 3'd0}) begin
            bad++;
            $display("FAIL single_ar_attr: got size=%0d burst=%0d want 6 1", m_axi_arsize,
                     m_axi_arburst);
        end
        total++;
        if (got.size() != 4) begin
            bad++;
            $display("FAIL single_nbeats: got %0d want 4", got.size());
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got_at(i) !== exp_beat(34'h1000, i, 256)) begin
                bad++;
                $display("FAIL single_beat%0d: got w=%h k=%h l=%b want w=%h k=%h l=%b", i,
                         got_at(i).d[31:0], got_at(i).k, got_at(i).l,
                         exp_beat(34'h1000, i, 256).d[31:0], exp_beat(34'h1000, i, 256).k,
                         exp_beat(34'h1000, i, 256).l);
            end
        end
    endtask

    task automatic test_4k_split();
        bit   ok;
        logic arv1, err1;
        int   cyc;
        ar_t  exp_ar[2];
        exp_ar[0] = {34'h0FC0, 8'd0};
        exp_ar[1] = {34'h1000, 8'd2};
        run_cmd(34'h0FC0, 200, ok, arv1, err1, cyc);
        total++;
        if (!ok) begin bad++; $display("FAIL split_done: got timeout want completion"); end
        total++;
        if (ar_log.size() != 2) begin
            bad++;
            $display("FAIL split_nar: got %0d want 2", ar_log.size());
        end
        for (int i = 0; i < 2; i++) begin
            total++;
            if (ar_at(i) !== exp_ar[i]) begin
                bad++;
                $display("FAIL split_ar%0d: got %h want %h", i, ar_at(i), exp_ar[i]);
            end
        end
        total++;
        if (got_at(3).k !== 64'h0000_0000_0000_00FF || got_at(3).l !== 1'b1) begin
            bad++;
            $display("FAIL split_last: got k=%h l=%b want k=00000000000000ff l=1", got_at(3).k,
                     got_at(3).l);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got_at(i) !== exp_beat(34'h0FC0, i, 200)) begin
                bad++;
                $display("FAIL split_beat%0d: got w=%h k=%h l=%b", i, got_at(i).d[31:0],
                         got_at(i).k, got_at(i).l);
            end
        end
    endtask

    task automatic test_zero_len();
        bit   ok;
        logic arv1, err1;
        int   cyc;
        int   hits;
        run_cmd(34'h2000, 0, ok, arv1, err1, cyc);
        total++;
        if (!ok || cyc != 0) begin
            bad++;
            $display("FAIL zero_ready: got ok=%0d wait=%0d want ok=1 wait=0", ok, cyc);
        end
        hits = int'(arv1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_axi_arvalid || m_axis_tvalid || busy) hits++;
        end
        total++;
        if (hits != 0 || ar_log.size() != 0 || got.size() != 0) begin
            bad++;
            $display("FAIL zero_traffic: got hits=%0d ar=%0d beats=%0d want 0 0 0", hits,
                     ar_log.size(), got.size());
        end
    endtask

    task automatic test_random_tready();
        bit   ok;
        logic arv1, err1;
        int   cyc;
        ar_t  exp_ar[3];
        exp_ar[0] = {34'h2000, 8'd15};
        exp_ar[1] = {34'h2400, 8'd15};
        exp_ar[2] = {34'h2800, 8'd7};
        tready_pct = 30;
        max_occ    = 0;
        run_cmd(34'h2000, 64 * 40, ok, arv1, err1, cyc);
        tready_pct = 100;
        total++;
        if (!ok) begin bad++; $display("FAIL rand_done: got timeout want completion"); end
        total++;
        if (ar_log.size() != 3) begin
            bad++;
            $display("FAIL rand_nar: got %0d want 3", ar_log.size());
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (ar_at(i) !== exp_ar[i]) begin
                bad++;
                $display("FAIL rand_ar%0d: got %h want %h", i, ar_at(i), exp_ar[i]);
            end
        end
        total++;
        if (got.size() != 40) begin
            bad++;
            $display("FAIL rand_nbeats: got %0d want 40", got.size());
        end
        for (int i = 0; i < 40; i++) begin
            total++;
            if (got_at(i) !== exp_beat(34'h2000, i, 64 * 40)) begin
                bad++;
                $display("FAIL rand_beat%0d: got w=%h k=%h l=%b", i, got_at(i).d[31:0],
                         got_at(i).k, got_at(i).l);
            end
        end
        total++;
        if (max_occ > 2) begin
            bad++;
            $display("FAIL rand_skid_occ: got %0d want <=2", max_occ);
        end
    endtask

    task automatic test_error();
        bit   ok;
        logic arv1, err1;
        int   cyc;
        err_beat = 1;
        run_cmd(34'h4000, 256, ok, arv1, err1, cyc);
        err_beat = -1;
        total++;
        if (!ok || error !== 1'b1) begin
            bad++;
            $display("FAIL err_set: got ok=%0d error=%b want 1 1", ok, error);
        end
        total++;
        if (got.size() != 4 || got_at(1) !== exp_beat(34'h4000, 1, 256) ||
            got_at(3) !== exp_beat(34'h4000, 3, 256)) begin
            bad++;
            $display("FAIL err_forward: got n=%0d w1=%h want n=4 w1=%h", got.size(),
                     got_at(1).d[31:0], 32'h4040);
        end
        run_cmd(34'h4100, 64, ok, arv1, err1, cyc);
        total++;
        if (err1 !== 1'b0) begin bad++; $display("FAIL err_clear: got %b want 0", err1); end
        total++;
        if (!ok || error !== 1'b0 || got_at(0) !== exp_beat(34'h4100, 0, 64) || got.size() != 1)
        begin
            bad++;
            $display("FAIL err_next: got err=%b n=%0d k=%h l=%b want 0 1 all-ones 1", error,
                     got.size(), got_at(0).k, got_at(0).l);
        end
    endtask

    task automatic test_reset_mid();
        bit   ok;
        logic arv1, err1;
        int   cyc;
        int   n;
        bit   acc;
        tready_pct = 0;
        resp_cnt   = 0;
        @(negedge clk);
        cmd_addr  = 34'h5000;
        cmd_len   = LW'(1024);
        cmd_valid = 1'b1;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            @(posedge clk);
            acc = cmd_ready;
            n++;
        end
        #1 cmd_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        total++;
        if (m_axis_tvalid !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_inflight: got tvalid=%b busy=%b want 1 1", m_axis_tvalid, busy);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({m_axis_tvalid, m_axi_arvalid, m_axi_rready, busy, error, cmd_ready} !== 6'b000001
            || m_axis_tdata !== '0) begin
            bad++;
            $display("FAIL mid_async: got tv/arv/rr/busy/err/rdy=%b want 000001",
                     {m_axis_tvalid, m_axi_arvalid, m_axi_rready, busy, error, cmd_ready});
        end
        repeat (3) @(negedge clk);
        ar_pend.delete();
        tready_pct = 100;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_release: got cmd_ready=%b want 1", cmd_ready);
        end
        run_cmd(34'h6000, 128, ok, arv1, err1, cyc);
        total++;
        if (!ok || ar_log.size() != 1 || ar_at(0) !== {34'h6000, 8'd1}) begin
            bad++;
            $display("FAIL mid_next_ar: got ok=%0d n=%0d ar=%h want 1 1 %h", ok, ar_log.size(),
                     ar_at(0), {34'h6000, 8'd1});
        end
        for (int i = 0; i < 2; i++) begin
            total++;
            if (got_at(i) !== exp_beat(34'h6000, i, 128)) begin
                bad++;
                $display("FAIL mid_next_beat%0d: got w=%h k=%h l=%b", i, got_at(i).d[31:0],
                         got_at(i).k, got_at(i).l);
            end
        end
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        total      = 0;
        bad        = 0;
        tready_pct = 100;
        err_beat   = -1;
        resp_cnt   = 0;
        max_occ    = 0;
        occ        = 0;
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_addr   = '0;
        cmd_len    = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_reset();
        test_single_burst();
        test_4k_split();
        test_zero_len();
        test_random_tready();
        test_error();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
